// File: rtl/wb_ps2_fifo.sv
// PS/2 receiver with filtered clock, framing checks and a Wishbone-mapped receive FIFO.
// Define PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES without a clock edge.
module wb_ps2_fifo #(
  parameter int DEV_ADDR_BITS   = 8,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  input  logic                     wbs_cs_i,
  input  logic [DEV_ADDR_BITS-1:2] wbs_addr_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_data_i,
  input  logic                     wbs_we_i,
  output logic [31:0]              wbs_data_o,
  output logic                     wbs_ack_o,
  output logic                     interrupt,
  output logic                     intererr
);
  localparam int AW    = DEV_ADDR_BITS - 2;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam int FW    = $clog2(FILTER_LEN) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic fall;
  state_e state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_q, bit_d;
  logic par_q, par_d;
  logic push_q, push_d;
  logic [7:0] pbyte_q;
  logic perr_set, ferr_set, tout_hit;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d, tout_q, tout_d;
  logic rx_ie_q, rx_ie_d, err_ie_q, err_ie_d, flush_q, flush_d;
  logic ack_q, int_q, int_d, ierr_q, ierr_d;
  logic [31:0] dout_q, dout_d, rdata;
  logic acc, rd, wr, a_data, a_stat, a_ctrl;
  logic empty, full, pop, do_push, w1c;
  logic unused_ok;

  assign unused_ok = ^{wbs_sel_i[3:1], wbs_data_i[31:5]};

  // Level change only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  assign tout_hit = (state_q != IDLE) && !fall
                    && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign tcnt_d = (state_q == IDLE || fall || tout_hit)
                  ? '0 : tcnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end
`else
  assign tout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tout_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!dat_s2_q) state_d = DATA;
        DATA:    if (bit_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sr_d     = sr_q;
    bit_d    = bit_q;
    par_d    = par_q;
    push_d   = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE:   bit_d = '0;
        DATA: begin
          sr_d  = {dat_s2_q, sr_q[7:1]};
          bit_d = bit_q + 1'b1;
        end
        PARITY: par_d = dat_s2_q;
        default: begin
          ferr_set = !dat_s2_q;
          perr_set = !(^{par_q, sr_q});
          push_d   = dat_s2_q & (^{par_q, sr_q});
        end
      endcase
    end
  end

  assign acc    = wbs_cs_i & ~ack_q;
  assign rd     = acc & ~wbs_we_i;
  assign wr     = acc & wbs_we_i & wbs_sel_i[0];
  assign a_data = wbs_addr_i == AW'(0);
  assign a_stat = wbs_addr_i == AW'(1);
  assign a_ctrl = wbs_addr_i == AW'(2);
  assign empty  = cnt_q == '0;
  assign full   = cnt_q == CW'(DEPTH);
  assign pop    = rd & a_data & ~empty;
  assign do_push = push_q & (~full | pop) & ~flush_q;
  assign w1c    = wr & a_stat;

  always_comb begin
    rdata = '0;
    if (a_data && !empty) begin
      rdata[8:0] = {1'b1, mem_q[rd_q]};
    end else if (a_stat) begin
      rdata[16 +: CW] = cnt_q;
      rdata[4:0] = {tout_q, ovf_q, ferr_q, perr_q, empty};
    end else if (a_ctrl) begin
      rdata[2:0] = {flush_q, err_ie_q, rx_ie_q};
    end
  end

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush_q) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (pop)     rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(pop);
    end
    perr_d = (perr_q & ~(w1c & wbs_data_i[1])) | perr_set;
    ferr_d = (ferr_q & ~(w1c & wbs_data_i[2])) | ferr_set;
    ovf_d  = (ovf_q & ~(w1c & wbs_data_i[3]))
             | (push_q & full & ~pop & ~flush_q);
    tout_d = (tout_q & ~(w1c & wbs_data_i[4])) | tout_hit;
    rx_ie_d  = rx_ie_q;
    err_ie_d = err_ie_q;
    flush_d  = 1'b0;
    if (wr && a_ctrl) begin
      rx_ie_d  = wbs_data_i[0];
      err_ie_d = wbs_data_i[1];
      flush_d  = wbs_data_i[2];
    end
    dout_d = rd ? rdata : '0;
    int_d  = rx_ie_q & ~empty;
    ierr_d = err_ie_q & (perr_q | ferr_q | ovf_q | tout_q);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= pbyte_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      sr_q     <= '0;
      bit_q    <= '0;
      par_q    <= 1'b0;
      push_q   <= 1'b0;
      pbyte_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tout_q   <= 1'b0;
      rx_ie_q  <= 1'b0;
      err_ie_q <= 1'b0;
      flush_q  <= 1'b0;
      ack_q    <= 1'b0;
      dout_q   <= '0;
      int_q    <= 1'b0;
      ierr_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      par_q    <= par_d;
      push_q   <= push_d;
      pbyte_q  <= sr_q;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      tout_q   <= tout_d;
      rx_ie_q  <= rx_ie_d;
      err_ie_q <= err_ie_d;
      flush_q  <= flush_d;
      ack_q    <= acc;
      dout_q   <= dout_d;
      int_q    <= int_d;
      ierr_q   <= ierr_d;
    end
  end

  assign wbs_data_o = dout_q;
  assign wbs_ack_o  = ack_q;
  assign interrupt  = int_q;
  assign intererr   = ierr_q;
endmodule

// File: tb/tb_wb_ps2_fifo.sv
// Directed bench for wb_ps2_fifo: frames, errors, overflow, glitches,
// flush, reset mid-frame and (with PS2_TIMEOUT_EN) frame timeout.
module tb_wb_ps2_fifo;
  localparam int TB_TOUT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        cs = 1'b0;
  logic [5:0]  addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        ack, irq, ierr;
  logic [31:0] d;
  int checks = 0;
  int failures = 0;

  wb_ps2_fifo #(
    .DEV_ADDR_BITS(8),
    .FIFO_DEPTH_BITS(4),
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TB_TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .wbs_cs_i(cs), .wbs_addr_i(addr), .wbs_sel_i(sel),
    .wbs_data_i(wdata), .wbs_we_i(we),
    .wbs_data_o(rdata), .wbs_ack_o(ack),
    .interrupt(irq), .intererr(ierr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_read(input logic [5:0] a, output logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a; sel = 4'h0;
    @(negedge clk);
    check("ack", {31'b0, ack}, 32'd1);
    v = rdata;
    cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] v);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; sel = 4'h1; wdata = v;
    @(negedge clk);
    check("wack", {31'b0, ack}, 32'd1);
    cs = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  // nbits < 11 stops the frame early; glitch_at injects three short
  // low pulses on ps2_clk in the high phase after that bit
  task automatic send(input logic [7:0] b, input bit bad_par,
                      input bit bad_stop, input int glitch_at,
                      input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      cyc(10);
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        repeat (3) begin
          cyc(3);
          ps2_clk = 1'b0;
          cyc(3);
          ps2_clk = 1'b1;
        end
      end
      cyc(10);
    end
    ps2_dat = 1'b1;
    cyc(20);
  endtask

  initial begin
    cyc(3);
    check("rst_dout", rdata, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_ierr", {31'b0, ierr}, 32'h0);
    rst = 1'b0;
    cyc(2);
    wb_read(6'd1, d); check("rst_status", d, 32'h0000_0001);
    wb_read(6'd2, d); check("rst_ctrl", d, 32'h0);

    // good frame 0x1C
    wb_write(6'd2, 32'h1);
    send(8'h1C, 0, 0, -1, 11);
    check("irq_set", {31'b0, irq}, 32'd1);
    wb_read(6'd1, d); check("stat_one", d, 32'h0001_0000);
    wb_read(6'd0, d); check("data_1c", d, 32'h0000_011C);
    check("irq_clr", {31'b0, irq}, 32'd0);
    wb_read(6'd1, d); check("stat_empty", d, 32'h0000_0001);
    wb_read(6'd0, d); check("data_empty", d, 32'h0);
    wb_read(6'd3, d); check("unmapped", d, 32'h0);

    // parity error
    wb_write(6'd2, 32'h3);
    send(8'h1C, 1, 0, -1, 11);
    wb_read(6'd1, d); check("stat_perr", d, 32'h0000_0003);
    check("ierr_perr", {31'b0, ierr}, 32'd1);
    wb_write(6'd1, 32'h2);
    wb_read(6'd1, d); check("perr_w1c", d, 32'h0000_0001);
    check("ierr_clr", {31'b0, ierr}, 32'd0);

    // framing error
    send(8'h33, 0, 1, -1, 11);
    wb_read(6'd1, d); check("stat_ferr", d, 32'h0000_0005);
    wb_write(6'd1, 32'h4);
    wb_read(6'd1, d); check("ferr_w1c", d, 32'h0000_0001);

    // overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) send(8'(i), 0, 0, -1, 11);
    wb_read(6'd1, d); check("stat_ovf", d, 32'h0010_0008);
    check("ierr_ovf", {31'b0, ierr}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      wb_read(6'd0, d); check("ovf_data", d, 32'h100 | 32'(i));
    end
    wb_read(6'd1, d); check("stat_drain", d, 32'h0000_0009);
    wb_write(6'd1, 32'h1E);
    wb_read(6'd1, d); check("ovf_w1c", d, 32'h0000_0001);

    // glitches on ps2_clk mid-frame
    send(8'h5A, 0, 0, 3, 11);
    wb_read(6'd1, d); check("stat_glitch", d, 32'h0001_0000);
    wb_read(6'd0, d); check("data_5a", d, 32'h0000_015A);

    // flush
    send(8'hA1, 0, 0, -1, 11);
    send(8'hA2, 0, 0, -1, 11);
    wb_read(6'd1, d); check("stat_two", d, 32'h0002_0000);
    wb_write(6'd2, 32'h7);
    wb_read(6'd1, d); check("stat_flush", d, 32'h0000_0001);
    wb_read(6'd2, d); check("ctrl_selfclr", d, 32'h0000_0003);

`ifdef PS2_TIMEOUT_EN
    send(8'hFF, 0, 0, -1, 5);
    cyc(TB_TOUT + 10);
    wb_read(6'd1, d); check("stat_tout", d, 32'h0000_0011);
    send(8'h29, 0, 0, -1, 11);
    wb_read(6'd1, d); check("stat_29", d, 32'h0001_0010);
    wb_read(6'd0, d); check("data_29", d, 32'h0000_0129);
    wb_write(6'd1, 32'h10);
    wb_read(6'd1, d); check("tout_w1c", d, 32'h0000_0001);
`endif

    // reset during bit 5 of a frame
    send(8'hC3, 0, 0, -1, 6);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    send(8'h76, 0, 0, -1, 11);
    wb_read(6'd1, d); check("stat_rst", d, 32'h0001_0000);
    check("irq_rst", {31'b0, irq}, 32'd0);
    wb_read(6'd0, d); check("data_76", d, 32'h0000_0176);
    wb_read(6'd1, d); check("stat_end", d, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
